// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: IDLE grants one request, EXEC drives the ALU, RESP holds the result.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with req0 winning ties.
module alu_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [2:0]      req0_opcode,
    input  logic            req0_signal,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [2:0]      req1_opcode,
    input  logic            req1_signal,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            alu_enable_n,
    output logic [2:0]      alu_opcode,
    output logic            alu_signal,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic            sig_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            id_q;
    logic [XLEN-1:0] res_q;
    logic            rsp_id_q;
    logic            rsp_valid_q;
    logic            alu_en_n_q;
    logic            busy_q;

`ifdef ALU_ARB_RR_EN
    // Set means req1 is favoured when both requesters are valid.
    logic            prio_q;
`endif

    logic            gnt0;
    logic            gnt1;
    logic            accept;
    logic [2:0]      op_d;
    logic            sig_d;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] b_d;

    // Grants are gated by rst_n so no ready is raised while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid && (!req1_valid || !prio_q)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
`else
            if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
`endif
        end
    end

    assign accept = gnt0 | gnt1;

    always_comb begin
        op_d  = req0_opcode;
        sig_d = req0_signal;
        a_d   = req0_a;
        b_d   = req0_b;
        if (gnt1) begin
            op_d  = req1_opcode;
            sig_d = req1_signal;
            a_d   = req1_a;
            b_d   = req1_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            sig_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            res_q       <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_en_n_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op_d;
                        sig_q      <= sig_d;
                        a_q        <= a_d;
                        b_q        <= b_d;
                        id_q       <= gnt1;
                        state_q    <= EXEC;
                        alu_en_n_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef ALU_ARB_RR_EN
                        prio_q     <= gnt0;
`endif
                    end
                end
                EXEC: begin
                    res_q       <= alu_result;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    alu_en_n_q  <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    alu_en_n_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign alu_enable_n = alu_en_n_q;
    assign alu_opcode   = op_q;
    assign alu_signal   = sig_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = res_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a reference ALU drives alu_result, and a transaction-level model predicts every output each cycle.
module tb_alu_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [2:0]      req0_opcode = '0, req1_opcode = '0;
    logic            req0_signal = 1'b0, req1_signal = 1'b0;
    logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic            alu_enable_n;
    logic [2:0]      alu_opcode;
    logic            alu_signal;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_result;
    logic            busy;

    int checks = 0;
    int failures = 0;

    // Model state: one outstanding operation at most.
    bit          m_busy;
    bit          m_exec;
    int          m_ptr;
    logic [2:0]  m_op;
    logic        m_sig;
    logic [31:0] m_a, m_b, m_res;
    int          m_id, m_rid;
    int          grants[$];

    typedef struct {
        int unsigned id;
        logic [2:0]  op;
        logic        sig;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];
    int   exp_order[4];

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_signal(req0_signal), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_signal(req1_signal), .req1_a(req1_a), .req1_b(req1_b),
        .alu_enable_n(alu_enable_n), .alu_opcode(alu_opcode), .alu_signal(alu_signal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return s ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return s ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_result = alu_f(alu_opcode, alu_signal, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_exec = 0; m_ptr = 0; m_op = '0; m_sig = 1'b0;
        m_a = '0; m_b = '0; m_res = '0; m_id = 0; m_rid = 0;
        grants.delete();
    endtask

    task automatic drive_req(input int unsigned id, input logic v, input logic [2:0] op,
                             input logic s, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_valid = v; req0_opcode = op; req0_signal = s; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_opcode = op; req1_signal = s; req1_a = a; req1_b = b;
        end
    endtask

    // Check all outputs against the model, advance the model, then cross one rising edge.
    task automatic tick();
        int winner;
        #1;
        winner = -1;
        if (!m_busy) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
                winner = m_ptr;
`else
                winner = 0;
`endif
            end else if (req0_valid) winner = 0;
            else if (req1_valid) winner = 1;
        end
        check("ready0", req0_ready, winner == 0);
        check("ready1", req1_ready, winner == 1);
        check("busy", busy, m_busy);
        check("rsp_valid", rsp_valid, m_busy && !m_exec);
        check("alu_enable_n", alu_enable_n, !(m_busy && m_exec));
        check("alu_cmd", {28'b0, alu_signal, alu_opcode}, {28'b0, m_sig, m_op});
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("rsp_result", rsp_result, m_res);
        if (m_busy && !m_exec) check("rsp_id", rsp_id, 32'(m_rid));
        if (req0_valid && req0_ready) grants.push_back(0);
        if (req1_valid && req1_ready) grants.push_back(1);
        if (winner == 0) begin
            m_op = req0_opcode; m_sig = req0_signal; m_a = req0_a; m_b = req0_b;
        end else if (winner == 1) begin
            m_op = req1_opcode; m_sig = req1_signal; m_a = req1_a; m_b = req1_b;
        end
        if (winner >= 0) begin
            m_busy = 1; m_exec = 1; m_id = winner; m_ptr = 1 - winner;
        end else if (m_busy && m_exec) begin
            m_res = alu_f(m_op, m_sig, m_a, m_b); m_rid = m_id; m_exec = 0;
        end else if (m_busy && rsp_ready) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rsp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_enable_n", alu_enable_n, 1);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_cmd", {28'b0, alu_signal, alu_opcode} | alu_a | alu_b, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rsp_ready = 1'b0;
        drive_req(v.id, 1'b1, v.op, v.sig, v.a, v.b);
        drive_req(1 - v.id, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check($sformatf("vec%0d_T1_enable_n", idx), alu_enable_n, 0);
        check($sformatf("vec%0d_T1_rsp_valid", idx), rsp_valid, 0);
        tick();
        #1;
        check($sformatf("vec%0d_T2_rsp_valid", idx), rsp_valid, 1);
        check($sformatf("vec%0d_T2_enable_n", idx), alu_enable_n, 1);
        check($sformatf("vec%0d_result", idx), rsp_result, v.exp);
        check($sformatf("vec%0d_id", idx), rsp_id, 32'(v.id));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0, 3'd0, 1'b1, 32'd10,         32'd3,          32'd7};
        vecs[1]  = '{1, 3'd5, 1'b1, 32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[2]  = '{0, 3'd0, 1'b0, 32'd5,          32'd6,          32'd11};
        vecs[3]  = '{1, 3'd1, 1'b0, 32'd1,          32'd31,         32'h8000_0000};
        vecs[4]  = '{0, 3'd2, 1'b0, 32'hFFFF_FFFF,  32'd0,          32'd1};
        vecs[5]  = '{1, 3'd3, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[6]  = '{0, 3'd4, 1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
        vecs[7]  = '{1, 3'd5, 1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[8]  = '{0, 3'd6, 1'b0, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
        vecs[9]  = '{1, 3'd7, 1'b0, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0F0F_0000};
        vecs[10] = '{0, 3'd0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0};
`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif

        do_reset();
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Both requesters valid continuously: observe the grant order.
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            drive_req(0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            drive_req(1, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            tick();
        end
        check("grant_count", grants.size() >= 4, 1);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check($sformatf("grant_order_%0d", k), grants[k], exp_order[k]);

        // Backpressure for 5 cycles, then handshake in the same cycle req0 is valid.
        do_reset();
        drive_req(0, 1'b1, 3'd0, 1'b1, 32'd10, 32'd3);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            rsp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            check("bp_result", rsp_result, 32'd7);
            check("bp_id", rsp_id, 0);
            check("bp_ready", {req1_ready, req0_ready}, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        rsp_ready = 1'b1; req1_valid = 1'b0; req0_valid = 1'b1;
        #1 check("hs_same_cycle_ready0", req0_ready, 0);
        tick();
        #1 check("hs_next_cycle_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();

        // Reset asserted while the operation is in EXEC.
        do_reset();
        drive_req(0, 1'b1, 3'd4, 1'b0, 32'h55, 32'hAA);
        tick();
        req0_valid = 1'b0;
        #1 check("exec_before_reset_enable_n", alu_enable_n, 0);
        rst_n = 1'b0;
        #1;
        check("exec_rst_rsp_valid", rsp_valid, 0);
        check("exec_rst_enable_n", alu_enable_n, 1);
        check("exec_rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 check("post_rst_no_rsp", rsp_valid, 0);
            tick();
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            drive_req(0, 1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), $urandom, $urandom);
            drive_req(1, 1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), $urandom, $urandom);
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
